wb_commit_stage: RTL and testbench
==================================

# wb_commit_stage

Parametrised writeback/commit stage of the five-stage LoongArch pipeline, sitting after the memory stage and driving the register file, the CSR file and the exception/ertn flush. Compared with the previous writeback stage it supports a configurable CSR read latency with a multi-cycle wait, single-cycle retire pulses, a prioritised exception vector with esubcode, and an instructions-retired counter.

## Interface
- `CSR_LAT`, default 1: CSR read latency in cycles, legal range 0..3. With 0, `csr_rvalue` is used in the same cycle.
- `EXC_N`, default 7: width of the exception vector, legal range 6..7.
- `CNT_W`, default 64: width of the retire counter.
- Ports, clock and reset first:
  - `clk`  in  1  clock
  - `resetn`  in  1  reset, synchronous, active-low
  - `ms2ws_valid`  in  1  memory stage holds an instruction
  - `ws_allowin`  out  1  WS can accept this cycle
  - `ms_pc`, `ms_vaddr`  in  32 each  PC and faulting address
  - `ms_exc`  in  EXC_N  exception vector; bit 0 INT, 1 ADEF, 2 ALE, 3 SYS, 4 BRK, 5 INE, 6 ADEM
  - `ms_ertn`  in  1  instruction is ertn
  - `ms_rf_we`  in  1  register write enable
  - `ms_rf_waddr`  in  5  register write address
  - `ms_rf_wdata`  in  32  register write data
  - `ms_csr_re`, `ms_csr_we`  in  1 each  CSR read enable, CSR write enable
  - `ms_csr_num`  in  14  CSR number
  - `ms_csr_wmask`, `ms_csr_wvalue`  in  32 each  CSR write mask and value
  - `csr_re`  out  1  CSR read enable
  - `csr_num`  out  14  CSR number
  - `csr_rvalue`  in  32  CSR read data
  - `csr_we`  out  1  CSR write enable
  - `csr_wmask`, `csr_wvalue`  out  32 each  CSR write mask and value
  - `wb_ex`, `ertn_flush`  out  1 each  one-cycle flush pulses
  - `wb_ecode`  out  6  exception code
  - `wb_esubcode`  out  9  exception subcode
  - `wb_pc`, `wb_vaddr`  out  32 each  PC and faulting address
  - `ws_rf_we`  out  1  forwarding: register write enable
  - `ws_rf_waddr`  out  5  forwarding: register write address
  - `ws_rf_wdata`  out  32  forwarding: register write data
  - `ws_fwd_busy`  out  1  forwarded data not yet valid; ID must stall
  - `instret`  out  CNT_W  instructions-retired counter
  - `debug_wb_pc`  out  32  debug trace PC
  - `debug_wb_rf_we`  out  4  debug trace write enable
  - `debug_wb_rf_wnum`  out  5  debug trace register number
  - `debug_wb_rf_wdata`  out  32  debug trace write data

## Operation
- **Load.** On `ms2ws_valid & ws_allowin` at a clock edge, capture all `ms_*` fields.
  - Set `ws_valid`.
  - Clear `wait_cnt` (2 bits).
- **Exception detect.**
  - `exc_any = ws_valid & |ws_exc`.
  - Priority goes to the lowest set index.
  - ecode per source: INT 0x0, ADEF 0x8, ALE 0x9, SYS 0xB, BRK 0xC, INE 0xD, ADEM 0x8 with esubcode 1.
  - esubcode is 0 for every other source.
  - With `EXC_N=6`, ADEM is absent.
- **Completion.** `ready_go = exc_any | ertn | ~csr_re_q | (wait_cnt == CSR_LAT)`.
  - While `ws_valid & csr_re_q & ~ready_go`, `wait_cnt` increments by 1 per cycle.
  - `wait_cnt` saturates at `CSR_LAT`.
- **Retire.** `retire = ws_valid & ready_go`.
  - On `retire & exc_any`: pulse `wb_ex` high for exactly that cycle.
  - On `retire & ertn & ~exc_any`: pulse `ertn_flush` high for exactly that cycle.
  - On `retire & ~exc_any & ~ertn`: normal commit. `csr_we` is high only in this cycle, and only if `ms_csr_we` was captured. `debug_wb_rf_we` is 4'hF if `rf_we`. `instret` increments by 1 (wrapping modulo 2^CNT_W).
  - ertn also increments `instret`; exceptions do not.
- **Register data.** `rf_wdata = csr_re_q ? csr_rvalue : wdata_q`.
- **CSR read enable.** `csr_re = ws_valid & csr_re_q & ~exc_any`.
- **Fixed-during-stay outputs.** `csr_num`, `csr_wmask`, `csr_wvalue`, `wb_pc` and `wb_vaddr` come from registers and hold steady throughout the instruction's stay in WS.
- **Forwarding.**
  - `ws_rf_we = ws_valid & rf_we & ~exc_any`.
  - `ws_fwd_busy = ws_rf_we & csr_re_q & ~ready_go`.
- **Flush.** On a `wb_ex` or `ertn_flush` cycle, `ws_valid` is cleared at the next edge and no load occurs that cycle: `ws_allowin` is forced to 0.
- **Allow-in.** `ws_allowin = (~ws_valid | retire) & ~wb_ex & ~ertn_flush`.

## Timing
- **Reset** (`resetn` low at an edge) clears:
  - `ws_valid`, `wait_cnt`, `instret` and all captured fields.
  - Consequently every output is 0 after reset, except `ws_allowin`, which is 1.
  - Reset mid-wait abandons the instruction: no retire, no pulses.
- **Latency by case:**
  - Non-CSR instruction: retires in its first WS cycle (1 cycle).
  - CSR read: retires after CSR_LAT+1 cycles in WS. While it waits, `ws_allowin` is 0, so the memory stage stalls.
  - `CSR_LAT=0` behaves exactly like the combinational predecessor.
- **Back-to-back.** A new instruction may load in the same edge at which the previous one retires, giving full throughput for non-CSR code.
- **Simultaneous events.**
  - An exception on a CSR-read instruction retires immediately: no wait, no `csr_re`.
  - Exception and ertn set together: the exception wins; `ertn_flush` stays 0.
- **Per-instruction pulse.** `debug_wb_rf_we`, `csr_we`, `wb_ex`, `ertn_flush` and the `instret` increment each occur at most once per instruction.
- **Counter wrap.** `instret` wraps from all-ones to 0.

## Test plan
- **Back-to-back ALU retire.** Drive 3 non-CSR ALU writes to r4, r5, r6 on consecutive cycles. Required:
  - 3 consecutive `debug_wb_rf_we = F` cycles.
  - `instret` goes 0→3.
  - `ws_allowin` stays 1.
- **CSR read wait.** Set `CSR_LAT=2` and issue a csrrd to r7 with `csr_rvalue = 0x1234`. Required:
  - `ws_fwd_busy` is 1 for 2 cycles.
  - `ws_allowin` is 0 for 2 cycles.
  - On the 3rd cycle, r7 is written with 0x1234, and `debug_wb_rf_we` is high for one cycle only.
- **Exception priority.** Drive `ms_exc = 7'b0010100` (ALE + BRK). Required:
  - `wb_ex` is a 1-cycle pulse with `wb_ecode = 0x9` and `wb_esubcode = 0`.
  - No RF write, no `csr_we`.
  - `instret` is unchanged.
  - `ws_valid` is 0 on the next cycle.
- **ADEM.** Drive `ms_exc = 7'b1000000` with `ms_vaddr = 0x8000_0003`. Required:
  - `wb_ecode = 0x8`, `wb_esubcode = 1`.
  - `wb_vaddr = 0x8000_0003`.
- **ertn with younger instruction.** Send an ertn with an ALU instruction right behind it. Required:
  - `ertn_flush` is high for 1 cycle.
  - `ws_allowin` is 0 in that cycle, so the ALU instruction is not loaded.
  - `instret` increments by 1.
- **Reset mid-wait, then counter wrap.** Assert reset during a CSR wait; required: all outputs 0, `ws_allowin` = 1. Then, with `CNT_W=4`, retire 16 instructions; required: `instret` returns to 0.

Source files
------------

// File: rtl/wb_commit_stage.sv
// rtl/wb_commit_stage.sv - writeback/commit stage with CSR read wait, exception vector and retire counter
module wb_commit_stage #(
  parameter int CSR_LAT = 1,
  parameter int EXC_N   = 7,
  parameter int CNT_W   = 64
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             ms2ws_valid,
  output logic             ws_allowin,
  input  logic [31:0]      ms_pc,
  input  logic [31:0]      ms_vaddr,
  input  logic [EXC_N-1:0] ms_exc,
  input  logic             ms_ertn,
  input  logic             ms_rf_we,
  input  logic [4:0]       ms_rf_waddr,
  input  logic [31:0]      ms_rf_wdata,
  input  logic             ms_csr_re,
  input  logic             ms_csr_we,
  input  logic [13:0]      ms_csr_num,
  input  logic [31:0]      ms_csr_wmask,
  input  logic [31:0]      ms_csr_wvalue,
  output logic             csr_re,
  output logic [13:0]      csr_num,
  input  logic [31:0]      csr_rvalue,
  output logic             csr_we,
  output logic [31:0]      csr_wmask,
  output logic [31:0]      csr_wvalue,
  output logic             wb_ex,
  output logic             ertn_flush,
  output logic [5:0]       wb_ecode,
  output logic [8:0]       wb_esubcode,
  output logic [31:0]      wb_pc,
  output logic [31:0]      wb_vaddr,
  output logic             ws_rf_we,
  output logic [4:0]       ws_rf_waddr,
  output logic [31:0]      ws_rf_wdata,
  output logic             ws_fwd_busy,
  output logic [CNT_W-1:0] instret,
  output logic [31:0]      debug_wb_pc,
  output logic [3:0]       debug_wb_rf_we,
  output logic [4:0]       debug_wb_rf_wnum,
  output logic [31:0]      debug_wb_rf_wdata
);

  localparam logic [1:0] LAT = 2'(CSR_LAT);

  logic             r_ws_valid;
  logic [1:0]       r_wait_cnt;
  logic [CNT_W-1:0] r_instret;
  logic [31:0]      r_pc;
  logic [31:0]      r_vaddr;
  logic [EXC_N-1:0] r_exc;
  logic             r_ertn;
  logic             r_rf_we;
  logic [4:0]       r_rf_waddr;
  logic [31:0]      r_wdata;
  logic             r_csr_re;
  logic             r_csr_we;
  logic [13:0]      r_csr_num;
  logic [31:0]      r_csr_wmask;
  logic [31:0]      r_csr_wvalue;

  logic        w_exc_any;
  logic        w_ready_go;
  logic        w_retire;
  logic        w_wb_ex;
  logic        w_ertn_flush;
  logic        w_commit;
  logic        w_allowin;
  logic        w_load;
  logic [31:0] w_rf_wdata;
  logic [5:0]  w_ecode;
  logic [8:0]  w_esubcode;

  // Exception cause index to LoongArch ecode; ADEM shares ADE's ecode
  function automatic logic [5:0] ecode_of(input int idx);
    case (idx)
      0:       ecode_of = 6'h00;
      1:       ecode_of = 6'h08;
      2:       ecode_of = 6'h09;
      3:       ecode_of = 6'h0B;
      4:       ecode_of = 6'h0C;
      5:       ecode_of = 6'h0D;
      6:       ecode_of = 6'h08;
      default: ecode_of = 6'h00;
    endcase
  endfunction

  assign w_exc_any    = r_ws_valid & (|r_exc);
  assign w_ready_go   = w_exc_any | r_ertn | ~r_csr_re | (r_wait_cnt == LAT);
  assign w_retire     = r_ws_valid & w_ready_go;
  assign w_wb_ex      = w_retire & w_exc_any;
  assign w_ertn_flush = w_retire & r_ertn & ~w_exc_any;
  assign w_commit     = w_retire & ~w_exc_any & ~r_ertn;
  assign w_allowin    = (~r_ws_valid | w_retire) & ~w_wb_ex & ~w_ertn_flush;
  assign w_load       = ms2ws_valid & w_allowin;
  assign w_rf_wdata   = r_csr_re ? csr_rvalue : r_wdata;

  // Lowest set cause wins: scan from the top so the last hit is the lowest index
  always_comb begin
    w_ecode    = 6'h00;
    w_esubcode = 9'h000;
    for (int i = EXC_N - 1; i >= 0; i--) begin
      if (r_exc[i]) begin
        w_ecode    = ecode_of(i);
        w_esubcode = (i == 6) ? 9'h001 : 9'h000;
      end
    end
    if (!w_exc_any) begin
      w_ecode    = 6'h00;
      w_esubcode = 9'h000;
    end
  end

  // Stage occupancy, CSR wait counter and captured instruction fields
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_ws_valid   <= 1'b0;
      r_wait_cnt   <= 2'd0;
      r_pc         <= '0;
      r_vaddr      <= '0;
      r_exc        <= '0;
      r_ertn       <= 1'b0;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_wdata      <= '0;
      r_csr_re     <= 1'b0;
      r_csr_we     <= 1'b0;
      r_csr_num    <= '0;
      r_csr_wmask  <= '0;
      r_csr_wvalue <= '0;
    end else if (w_load) begin
      r_ws_valid   <= 1'b1;
      r_wait_cnt   <= 2'd0;
      r_pc         <= ms_pc;
      r_vaddr      <= ms_vaddr;
      r_exc        <= ms_exc;
      r_ertn       <= ms_ertn;
      r_rf_we      <= ms_rf_we;
      r_rf_waddr   <= ms_rf_waddr;
      r_wdata      <= ms_rf_wdata;
      r_csr_re     <= ms_csr_re;
      r_csr_we     <= ms_csr_we;
      r_csr_num    <= ms_csr_num;
      r_csr_wmask  <= ms_csr_wmask;
      r_csr_wvalue <= ms_csr_wvalue;
    end else if (w_retire) begin
      r_ws_valid <= 1'b0;
    end else if (r_ws_valid & r_csr_re & (r_wait_cnt != LAT)) begin
      r_wait_cnt <= r_wait_cnt + 2'd1;
    end
  end

  // Retired-instruction counter: normal commits and ertn count, exceptions do not
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_instret <= '0;
    end else if (w_commit | w_ertn_flush) begin
      r_instret <= r_instret + CNT_W'(1);
    end
  end

  assign ws_allowin        = w_allowin;
  assign csr_re            = r_ws_valid & r_csr_re & ~w_exc_any;
  assign csr_num           = r_csr_num;
  assign csr_we            = w_commit & r_csr_we;
  assign csr_wmask         = r_csr_wmask;
  assign csr_wvalue        = r_csr_wvalue;
  assign wb_ex             = w_wb_ex;
  assign ertn_flush        = w_ertn_flush;
  assign wb_ecode          = w_ecode;
  assign wb_esubcode       = w_esubcode;
  assign wb_pc             = r_pc;
  assign wb_vaddr          = r_vaddr;
  assign ws_rf_we          = r_ws_valid & r_rf_we & ~w_exc_any;
  assign ws_rf_waddr       = r_rf_waddr;
  assign ws_rf_wdata       = w_rf_wdata;
  assign ws_fwd_busy       = r_ws_valid & r_rf_we & ~w_exc_any & r_csr_re & ~w_ready_go;
  assign instret           = r_instret;
  assign debug_wb_pc       = r_pc;
  assign debug_wb_rf_we    = {4{w_commit & r_rf_we}};
  assign debug_wb_rf_wnum  = r_rf_waddr;
  assign debug_wb_rf_wdata = w_rf_wdata;

endmodule

// File: tb/tb_wb_commit_stage.sv
// tb/tb_wb_commit_stage.sv - directed bench for wb_commit_stage with a cycle-level reference model
module tb_wb_commit_stage;

  localparam int CSR_LAT = 2;
  localparam int EXC_N   = 7;
  localparam int CNT_W   = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] vaddr;
    logic [6:0]  exc;
    logic        ertn;
    logic        rf_we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        csr_re;
    logic        csr_we;
    logic [13:0] num;
    logic [31:0] wmask;
    logic [31:0] wvalue;
  } ins_t;

  logic clk = 1'b0;
  logic resetn;
  logic in_valid;
  ins_t in_i;
  logic [31:0] csr_rvalue;

  logic             ws_allowin, csr_re, csr_we, wb_ex, ertn_flush, ws_rf_we, ws_fwd_busy;
  logic [13:0]      csr_num;
  logic [31:0]      csr_wmask, csr_wvalue, wb_pc, wb_vaddr, ws_rf_wdata, debug_wb_pc, debug_wb_rf_wdata;
  logic [5:0]       wb_ecode;
  logic [8:0]       wb_esubcode;
  logic [4:0]       ws_rf_waddr, debug_wb_rf_wnum;
  logic [3:0]       debug_wb_rf_we;
  logic [CNT_W-1:0] instret;

  always #5 clk = ~clk;

  wb_commit_stage #(.CSR_LAT(CSR_LAT), .EXC_N(EXC_N), .CNT_W(CNT_W)) dut (
    .clk(clk), .resetn(resetn), .ms2ws_valid(in_valid), .ws_allowin(ws_allowin),
    .ms_pc(in_i.pc), .ms_vaddr(in_i.vaddr), .ms_exc(in_i.exc), .ms_ertn(in_i.ertn),
    .ms_rf_we(in_i.rf_we), .ms_rf_waddr(in_i.waddr), .ms_rf_wdata(in_i.wdata),
    .ms_csr_re(in_i.csr_re), .ms_csr_we(in_i.csr_we), .ms_csr_num(in_i.num),
    .ms_csr_wmask(in_i.wmask), .ms_csr_wvalue(in_i.wvalue),
    .csr_re(csr_re), .csr_num(csr_num), .csr_rvalue(csr_rvalue), .csr_we(csr_we),
    .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue), .wb_ex(wb_ex), .ertn_flush(ertn_flush),
    .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode), .wb_pc(wb_pc), .wb_vaddr(wb_vaddr),
    .ws_rf_we(ws_rf_we), .ws_rf_waddr(ws_rf_waddr), .ws_rf_wdata(ws_rf_wdata),
    .ws_fwd_busy(ws_fwd_busy), .instret(instret), .debug_wb_pc(debug_wb_pc),
    .debug_wb_rf_we(debug_wb_rf_we), .debug_wb_rf_wnum(debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  int n_checks = 0;
  int n_err    = 0;

  // reference model: the instruction sitting in WS and how many cycles it has been there
  logic             m_valid;
  int               m_cycles;
  ins_t             m;
  logic [CNT_W-1:0] m_instret;

  // observed-event tallies for the hand-computed expectations
  int c_rfwe, c_busy, c_noallow, c_wbex, c_ertn, c_csrre, c_csrwe;
  logic [31:0] last_wdata;
  logic [4:0]  last_wnum;
  logic [5:0]  last_ecode;
  logic [8:0]  last_esub;
  logic [31:0] last_vaddr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [5:0] cause_code(input int idx);
    case (idx)
      0: return 6'h0;  1: return 6'h8;  2: return 6'h9;  3: return 6'hB;
      4: return 6'hC;  5: return 6'hD;  6: return 6'h8;  default: return 6'h0;
    endcase
  endfunction

  // model-derived view of the current cycle
  logic e_exc, e_ret, e_ex, e_ertn, e_commit, e_allow;

  task automatic model_eval();
    e_exc    = m_valid && (m.exc != 0);
    e_ret    = m_valid && (e_exc || m.ertn || !m.csr_re || (m_cycles >= CSR_LAT));
    e_ex     = e_ret && e_exc;
    e_ertn   = e_ret && m.ertn && !e_exc;
    e_commit = e_ret && !e_exc && !m.ertn;
    e_allow  = (!m_valid || e_ret) && !e_ex && !e_ertn;
  endtask

  task automatic check_outputs();
    int idx;
    logic [31:0] e_wd;
    logic e_rfwe;
    model_eval();
    idx = -1;
    for (int i = EXC_N - 1; i >= 0; i--) if (m.exc[i]) idx = i;
    e_wd   = m.csr_re ? csr_rvalue : m.wdata;
    e_rfwe = m_valid && m.rf_we && !e_exc;
    chk("ws_allowin", 64'(ws_allowin), 64'(e_allow));
    chk("csr_re", 64'(csr_re), 64'(m_valid && m.csr_re && !e_exc));
    chk("csr_num", 64'(csr_num), 64'(m.num));
    chk("csr_we", 64'(csr_we), 64'(e_commit && m.csr_we));
    chk("csr_wmask", 64'(csr_wmask), 64'(m.wmask));
    chk("csr_wvalue", 64'(csr_wvalue), 64'(m.wvalue));
    chk("wb_ex", 64'(wb_ex), 64'(e_ex));
    chk("ertn_flush", 64'(ertn_flush), 64'(e_ertn));
    if (e_ex) begin
      chk("wb_ecode", 64'(wb_ecode), 64'(cause_code(idx)));
      chk("wb_esubcode", 64'(wb_esubcode), (idx == 6) ? 64'd1 : 64'd0);
    end
    chk("wb_pc", 64'(wb_pc), 64'(m.pc));
    chk("wb_vaddr", 64'(wb_vaddr), 64'(m.vaddr));
    chk("ws_rf_we", 64'(ws_rf_we), 64'(e_rfwe));
    chk("ws_rf_waddr", 64'(ws_rf_waddr), 64'(m.waddr));
    chk("ws_rf_wdata", 64'(ws_rf_wdata), 64'(e_wd));
    chk("ws_fwd_busy", 64'(ws_fwd_busy), 64'(e_rfwe && m.csr_re && !e_ret));
    chk("instret", 64'(instret), 64'(m_instret));
    chk("debug_wb_pc", 64'(debug_wb_pc), 64'(m.pc));
    chk("debug_wb_rf_we", 64'(debug_wb_rf_we), (e_commit && m.rf_we) ? 64'hF : 64'h0);
    chk("debug_wb_rf_wnum", 64'(debug_wb_rf_wnum), 64'(m.waddr));
    chk("debug_wb_rf_wdata", 64'(debug_wb_rf_wdata), 64'(e_wd));
    if (debug_wb_rf_we == 4'hF) begin
      c_rfwe++;
      last_wdata = debug_wb_rf_wdata;
      last_wnum  = debug_wb_rf_wnum;
    end
    if (ws_fwd_busy) c_busy++;
    if (!ws_allowin) c_noallow++;
    if (csr_re) c_csrre++;
    if (csr_we) c_csrwe++;
    if (ertn_flush) c_ertn++;
    if (wb_ex) begin
      c_wbex++;
      last_ecode = wb_ecode;
      last_esub  = wb_esubcode;
      last_vaddr = wb_vaddr;
    end
  endtask

  task automatic model_update();
    if (!resetn) begin
      m_valid = 1'b0; m_cycles = 0; m = '0; m_instret = '0;
    end else begin
      model_eval();
      if (e_commit || e_ertn) m_instret = m_instret + 1'b1;
      if (e_allow && in_valid) begin
        m = in_i; m_valid = 1'b1; m_cycles = 0;
      end else if (e_ret) begin
        m_valid = 1'b0;
      end else if (m_valid) begin
        m_cycles++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clr_tally();
    c_rfwe = 0; c_busy = 0; c_noallow = 0; c_wbex = 0; c_ertn = 0; c_csrre = 0; c_csrwe = 0;
  endtask

  function automatic ins_t alu(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
    ins_t t;
    t = '0; t.pc = pc; t.rf_we = 1'b1; t.waddr = wa; t.wdata = wd;
    return t;
  endfunction

  logic [CNT_W-1:0] saved;

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_i = '0; csr_rvalue = 32'h0;
    m_valid = 1'b0; m_cycles = 0; m = '0; m_instret = '0;
    clr_tally();
    @(posedge clk); #1;
    step(); step();
    resetn = 1'b1;
    chk("reset_allowin", 64'(ws_allowin), 64'd1);
    chk("reset_instret", 64'(instret), 64'd0);

    // back-to-back ALU retire
    clr_tally();
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_i = alu(32'h1c00_0000 + 32'(4 * k), 5'(4 + k), 32'hA000 + 32'(k));
      step();
    end
    in_valid = 1'b0;
    step();
    chk("b2b_rfwe_cycles", 64'(c_rfwe), 64'd3);
    chk("b2b_instret", 64'(instret), 64'd3);
    chk("b2b_no_stall", 64'(c_noallow), 64'd0);

    // CSR read with a two-cycle wait
    clr_tally();
    in_i = alu(32'h1c00_0100, 5'd7, 32'hDEAD); in_i.csr_re = 1'b1; in_i.num = 14'h005;
    csr_rvalue = 32'h1234; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (4) step();
    chk("csrrd_busy", 64'(c_busy), 64'd2);
    chk("csrrd_stall", 64'(c_noallow), 64'd2);
    chk("csrrd_rfwe", 64'(c_rfwe), 64'd1);
    chk("csrrd_wdata", 64'(last_wdata), 64'h1234);
    chk("csrrd_wnum", 64'(last_wnum), 64'd7);
    chk("csrrd_instret", 64'(instret), 64'd4);

    // CSR write commit
    clr_tally();
    in_i = '0; in_i.pc = 32'h1c00_0200; in_i.csr_we = 1'b1; in_i.num = 14'h006;
    in_i.wmask = 32'h0000_00FF; in_i.wvalue = 32'h5A; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("csrwr_once", 64'(c_csrwe), 64'd1);

    // exception priority: ALE + BRK on an instruction that also reads/writes CSRs
    clr_tally();
    saved = instret;
    in_i = alu(32'h1c00_0300, 5'd8, 32'h1); in_i.exc = 7'b0010100;
    in_i.csr_re = 1'b1; in_i.csr_we = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("exc_pulses", 64'(c_wbex), 64'd1);
    chk("exc_ecode", 64'(last_ecode), 64'h9);
    chk("exc_esub", 64'(last_esub), 64'd0);
    chk("exc_no_rfwe", 64'(c_rfwe), 64'd0);
    chk("exc_no_csrwe", 64'(c_csrwe), 64'd0);
    chk("exc_no_csrre", 64'(c_csrre), 64'd0);
    chk("exc_instret", 64'(instret), 64'(saved));

    // ADEM
    clr_tally();
    in_i = '0; in_i.pc = 32'h1c00_0400; in_i.vaddr = 32'h8000_0003; in_i.exc = 7'b1000000;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("adem_ecode", 64'(last_ecode), 64'h8);
    chk("adem_esub", 64'(last_esub), 64'd1);
    chk("adem_vaddr", 64'(last_vaddr), 64'h8000_0003);

    // ertn with a younger ALU instruction right behind it
    clr_tally();
    in_i = '0; in_i.pc = 32'h1c00_0500; in_i.ertn = 1'b1; in_valid = 1'b1;
    step();
    saved = instret;
    in_i = alu(32'h1c00_0504, 5'd9, 32'h99);
    step();
    chk("ertn_instret", 64'(instret), 64'(saved + 1'b1));
    chk("ertn_blocked", 64'(c_noallow), 64'd1);
    step();
    in_valid = 1'b0;
    step(); step();
    chk("ertn_pulses", 64'(c_ertn), 64'd1);
    chk("ertn_alu_rfwe", 64'(c_rfwe), 64'd1);

    // exception together with ertn: exception wins
    clr_tally();
    in_i = '0; in_i.pc = 32'h1c00_0600; in_i.ertn = 1'b1; in_i.exc = 7'b0000001; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    chk("excertn_wbex", 64'(c_wbex), 64'd1);
    chk("excertn_no_ertn", 64'(c_ertn), 64'd0);
    chk("excertn_ecode", 64'(last_ecode), 64'h0);

    // reset in the middle of a CSR wait
    clr_tally();
    in_i = alu(32'h1c00_0700, 5'd10, 32'h77); in_i.csr_re = 1'b1; in_i.num = 14'h00C;
    in_i.wmask = 32'hFFFF_FFFF; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    resetn = 1'b0;
    step();
    chk("rst_allowin", 64'(ws_allowin), 64'd1);
    chk("rst_instret", 64'(instret), 64'd0);
    chk("rst_outputs", 64'({csr_re, csr_we, wb_ex, ertn_flush, ws_rf_we, ws_fwd_busy, debug_wb_rf_we}), 64'd0);
    chk("rst_fields", 64'(wb_pc | csr_wmask | ws_rf_wdata | debug_wb_pc), 64'd0);
    resetn = 1'b1;
    step();
    chk("rst_no_retire", 64'(c_rfwe + c_wbex + c_ertn), 64'd0);

    // counter wrap: 16 retires on a 4-bit counter
    clr_tally();
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1; in_i = alu(32'h1c00_1000 + 32'(4 * k), 5'(k + 1), 32'(k));
      step();
    end
    in_valid = 1'b0;
    step();
    chk("wrap_rfwe", 64'(c_rfwe), 64'd16);
    chk("wrap_instret", 64'(instret), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
